packet_disassembler: RTL and testbench

Receive-side counterpart of the HDMI data island packet path. Consumes the 9-bit per-pixel packet word recovered from TERC4 decoding on TMDS channels 0–2 during a data island period. Rebuilds the 24-bit header and four 56-bit subpackets over 32 pixels, and checks the BCH ECC of all five blocks. Sits between the TMDS/TERC4 decoder and packet consumers (InfoFrame parser, audio sample extractor).

---
 rtl/hdmi_packet_pkg.sv | 20 ++
 rtl/bch_ecc_accumulator.sv | 40 ++++
 rtl/packet_disassembler.sv | 137 +++++++++++++
 tb/tb_packet_disassembler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared HDMI data island packet geometry and the BCH(64,56)/(32,24) parity step
// used by both the transmit-side assembler and the receive-side disassembler.
package hdmi_packet_pkg;

   localparam logic [7:0] BCH_POLY       = 8'b1000_0011;
   localparam int         PACKET_WORDS   = 32;
   localparam int         HEADER_BITS    = 24;
   localparam int         SUB_BITS       = 56;
   localparam int         ECC_BITS       = 8;
   localparam int         NUM_SUBS       = 4;
   localparam int         SUB_DATA_WORDS = SUB_BITS / 2;

   // One bit-serial step of the parity LFSR; LSB-first data order.
   function automatic logic [7:0] next_ecc(input logic [7:0] ecc, input logic data_bit);
      logic [7:0] shifted;
      shifted = ecc >> 1;
      return (ecc[0] ^ data_bit) ? (shifted ^ BCH_POLY) : shifted;
   endfunction

endpackage

// File: rtl/bch_ecc_accumulator.sv
// Running BCH parity over one block, folding BITS_PER_CYCLE bits per clock
// (data_bits[0] is the earlier bit in stream order).
module bch_ecc_accumulator
   import hdmi_packet_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic                      clk_pixel,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      enable,
   input  logic [BITS_PER_CYCLE-1:0] data_bits,
   output logic [ECC_BITS-1:0]       ecc
);

   logic [ECC_BITS-1:0] ecc_q;
   logic [ECC_BITS-1:0] ecc_d;

   always_comb begin
      ecc_d = ecc_q;
      if (clear) begin
         ecc_d = '0;
      end else if (enable) begin
         for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            ecc_d = next_ecc(ecc_d, data_bits[k]);
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         ecc_q <= '0;
      end else begin
         ecc_q <= ecc_d;
      end
   end

   assign ecc = ecc_q;

endmodule

// File: rtl/packet_disassembler.sv
// Rebuilds an HDMI data island packet (header + four subpackets) from 32 TERC4
// packet words and reports per-block BCH parity agreement.
module packet_disassembler
   import hdmi_packet_pkg::*;
(
   input  logic                   clk_pixel,
   input  logic                   reset,
   input  logic                   data_island_period,
   input  logic [8:0]             packet_data,
   output logic [HEADER_BITS-1:0] header,
   output logic [SUB_BITS-1:0]    sub [NUM_SUBS],
   output logic                   header_ecc_ok,
   output logic [NUM_SUBS-1:0]    sub_ecc_ok,
   output logic                   packet_valid,
   output logic                   packet_aborted
);

   // Flow control: a word is accepted on every rising edge where
   // data_island_period is high (no backpressure); packet_valid and
   // packet_aborted are single-cycle pulses, header/sub/ecc flags hold otherwise.

   localparam logic [4:0] LAST_WORD     = 5'(PACKET_WORDS - 1);
   localparam int         BCH_WORD_BITS = SUB_BITS + ECC_BITS;

   logic [4:0]                                cnt_q, cnt_d;
   logic [PACKET_WORDS-1:0]                   bch4_q, bch4_d;
   logic [NUM_SUBS-1:0][BCH_WORD_BITS-1:0]    bch_q, bch_d;
   logic [HEADER_BITS-1:0]                    header_q, header_d;
   logic [NUM_SUBS-1:0][SUB_BITS-1:0]         sub_q, sub_d;
   logic                                      header_ok_q, header_ok_d;
   logic [NUM_SUBS-1:0]                       sub_ok_q, sub_ok_d;
   logic                                      valid_q, valid_d;
   logic                                      aborted_q, aborted_d;

   logic                                      last_word;
   logic                                      hdr_en;
   logic                                      sub_en;
   logic                                      acc_clear;
   logic [ECC_BITS-1:0]                       hdr_ecc;
   logic [NUM_SUBS-1:0][ECC_BITS-1:0]         sub_ecc;

   always_comb begin
      last_word = data_island_period && (cnt_q == LAST_WORD);
      hdr_en    = data_island_period && (cnt_q < 5'(HEADER_BITS));
      sub_en    = data_island_period && (cnt_q < 5'(SUB_DATA_WORDS));
      acc_clear = !data_island_period || (cnt_q == LAST_WORD);
   end

   bch_ecc_accumulator #(.BITS_PER_CYCLE(1)) u_hdr_ecc (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .clear     (acc_clear),
      .enable    (hdr_en),
      .data_bits (packet_data[0:0]),
      .ecc       (hdr_ecc)
   );

   for (genvar g = 0; g < NUM_SUBS; g++) begin : g_sub_ecc
      bch_ecc_accumulator #(.BITS_PER_CYCLE(2)) u_sub_ecc (
         .clk_pixel (clk_pixel),
         .reset     (reset),
         .clear     (acc_clear),
         .enable    (sub_en),
         .data_bits ({packet_data[5+g], packet_data[1+g]}),
         .ecc       (sub_ecc[g])
      );
   end

   // Every bit position is rewritten before the next completion, so a partial
   // packet left behind by an abort never needs an explicit flush.
   always_comb begin
      cnt_d  = data_island_period ? cnt_q + 5'd1 : '0;
      bch4_d = bch4_q;
      bch_d  = bch_q;
      if (data_island_period) begin
         bch4_d[cnt_q] = packet_data[0];
         for (int i = 0; i < NUM_SUBS; i++) begin
            bch_d[i][{cnt_q, 1'b0}] = packet_data[1+i];
            bch_d[i][{cnt_q, 1'b1}] = packet_data[5+i];
         end
      end
   end

   always_comb begin
      header_d    = header_q;
      sub_d       = sub_q;
      header_ok_d = header_ok_q;
      sub_ok_d    = sub_ok_q;
      valid_d     = last_word;
      aborted_d   = !data_island_period && (cnt_q != '0);
      if (last_word) begin
         header_d    = bch4_d[HEADER_BITS-1:0];
         header_ok_d = (bch4_d[PACKET_WORDS-1 -: ECC_BITS] == hdr_ecc);
         for (int i = 0; i < NUM_SUBS; i++) begin
            sub_d[i]    = bch_d[i][SUB_BITS-1:0];
            sub_ok_d[i] = (bch_d[i][BCH_WORD_BITS-1 -: ECC_BITS] == sub_ecc[i]);
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         cnt_q       <= '0;
         bch4_q      <= '0;
         bch_q       <= '0;
         header_q    <= '0;
         sub_q       <= '0;
         header_ok_q <= 1'b0;
         sub_ok_q    <= '0;
         valid_q     <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         bch4_q      <= bch4_d;
         bch_q       <= bch_d;
         header_q    <= header_d;
         sub_q       <= sub_d;
         header_ok_q <= header_ok_d;
         sub_ok_q    <= sub_ok_d;
         valid_q     <= valid_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SUBS; i++) begin
         sub[i] = sub_q[i];
      end
   end

   assign header         = header_q;
   assign header_ecc_ok  = header_ok_q;
   assign sub_ecc_ok     = sub_ok_q;
   assign packet_valid   = valid_q;
   assign packet_aborted = aborted_q;

endmodule

// File: tb/tb_packet_disassembler.sv
// Bench for packet_disassembler: builds packets as plain bit vectors, serialises
// them into words, and checks every completion against a queue of expected packets.
module tb_packet_disassembler;

   localparam int EXP_W = 253;

   logic        clk_pixel;
   logic        reset;
   logic        data_island_period;
   logic [8:0]  packet_data;
   logic [23:0] header;
   logic [55:0] sub [4];
   logic        header_ecc_ok;
   logic [3:0]  sub_ecc_ok;
   logic        packet_valid;
   logic        packet_aborted;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int valid_cnt = 0;
   int abort_cnt = 0;
   int exp_abort = 0;
   int pushed = 0;

   logic [EXP_W-1:0] exp_q[$];
   int               exp_cyc_q[$];
   int               valid_cycles[$];
   logic [EXP_W-1:0] last_exp = '0;
   logic [EXP_W-1:0] mon_e;
   int               mon_c;

   packet_disassembler dut (
      .clk_pixel          (clk_pixel),
      .reset              (reset),
      .data_island_period (data_island_period),
      .packet_data        (packet_data),
      .header             (header),
      .sub                (sub),
      .header_ecc_ok      (header_ecc_ok),
      .sub_ecc_ok         (sub_ecc_ok),
      .packet_valid       (packet_valid),
      .packet_aborted     (packet_aborted)
   );

   // clock / cycle counter
   initial clk_pixel = 1'b0;
   always #5 clk_pixel = ~clk_pixel;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bit-serial polynomial division of the first n bits, LSB first.
   function automatic logic [7:0] ref_ecc(input logic [63:0] bits, input int n);
      logic [7:0] e;
      e = '0;
      for (int k = 0; k < n; k++) begin
         if (e[0] ^ bits[k]) e = (e >> 1) ^ 8'h83;
         else                e = e >> 1;
      end
      return e;
   endfunction

   function automatic logic [31:0] make_b4(input logic [23:0] h);
      return {ref_ecc(64'(h), 24), h};
   endfunction

   function automatic logic [63:0] make_b(input logic [55:0] s);
      return {ref_ecc(64'(s), 56), s};
   endfunction

   // Expected outputs: {header_ok, sub_ok[3:0], header, sub3, sub2, sub1, sub0}
   function automatic logic [EXP_W-1:0] model(input logic [31:0] b4, input logic [3:0][63:0] b);
      logic       hok;
      logic [3:0] sok;
      hok = (b4[31:24] == ref_ecc(64'(b4[23:0]), 24));
      for (int i = 0; i < 4; i++) sok[i] = (b[i][63:56] == ref_ecc(64'(b[i][55:0]), 56));
      return {hok, sok, b4[23:0], b[3][55:0], b[2][55:0], b[1][55:0], b[0][55:0]};
   endfunction

   task automatic check_outputs(input string tag, input logic [EXP_W-1:0] e);
      check({tag, "_header"}, 256'(header), 256'(e[247:224]));
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s_sub%0d", tag, i), 256'(sub[i]), 256'(e[i*56 +: 56]));
      end
      check({tag, "_header_ok"}, 256'(header_ecc_ok), 256'(e[252]));
      check({tag, "_sub_ok"}, 256'(sub_ecc_ok), 256'(e[251:248]));
   endtask

   // driver tasks
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk_pixel);
         data_island_period = 1'b0;
         packet_data        = 9'($urandom);
      end
   endtask

   task automatic send_pkt(input logic [31:0] b4, input logic [3:0][63:0] b, input int nwords);
      for (int c = 0; c < nwords; c++) begin
         @(negedge clk_pixel);
         data_island_period = 1'b1;
         packet_data[0] = b4[c];
         for (int i = 0; i < 4; i++) begin
            packet_data[1+i] = b[i][2*c];
            packet_data[5+i] = b[i][2*c+1];
         end
         if (c == 31) begin
            last_exp = model(b4, b);
            exp_q.push_back(last_exp);
            exp_cyc_q.push_back(cyc + 1);
            pushed++;
         end
      end
   endtask

   task automatic rand_pkt(output logic [31:0] b4, output logic [3:0][63:0] b);
      b4 = make_b4(24'($urandom));
      for (int i = 0; i < 4; i++) b[i] = make_b({24'($urandom), $urandom});
   endtask

   // scoreboard: every packet_valid pulse consumes one expected packet
   always @(negedge clk_pixel) begin
      if (packet_aborted) abort_cnt++;
      if (packet_valid) begin
         valid_cnt++;
         valid_cycles.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 256'(1), 256'(0));
         end else begin
            mon_e = exp_q.pop_front();
            mon_c = exp_cyc_q.pop_front();
            check("valid_latency", 256'(cyc), 256'(mon_c));
            check_outputs("pkt", mon_e);
         end
      end
   end

   initial begin
      logic [31:0]      b4;
      logic [3:0][63:0] b;
      logic [55:0]      keep_sub2;
      logic [EXP_W-1:0] prior;
      int               a0, v0, sz, r, n, bi, si;

      reset              = 1'b1;
      data_island_period = 1'b0;
      packet_data        = '0;
      repeat (3) @(negedge clk_pixel);
      check_outputs("reset", '0);
      check("reset_valid", 256'(packet_valid), 256'(0));
      check("reset_aborted", 256'(packet_aborted), 256'(0));
      reset = 1'b0;
      idle(2);

      // 1: all-zero packet
      send_pkt('0, '0, 32);
      idle(2);
      check("t1_header", 256'(header), 256'(0));
      check("t1_header_ok", 256'(header_ecc_ok), 256'(1));
      check("t1_sub_ok", 256'(sub_ecc_ok), 256'(4'b1111));

      // 2: known header, then the same header with bit 5 flipped after parity
      rand_pkt(b4, b);
      b4 = make_b4(24'h0D0282);
      send_pkt(b4, b, 32);
      idle(2);
      check("t2_header", 256'(header), 256'(24'h0D0282));
      check("t2_header_ok", 256'(header_ecc_ok), 256'(1));
      b4[5] = ~b4[5];
      send_pkt(b4, b, 32);
      idle(2);
      check("t2_flip_header_ok", 256'(header_ecc_ok), 256'(0));
      check("t2_flip_sub_ok", 256'(sub_ecc_ok), 256'(4'b1111));

      // 3: parity bit 60 of subpacket 2 inverted
      rand_pkt(b4, b);
      keep_sub2 = b[2][55:0];
      b[2][60] = ~b[2][60];
      send_pkt(b4, b, 32);
      idle(2);
      check("t3_sub_ok", 256'(sub_ecc_ok), 256'(4'b1011));
      check("t3_header_ok", 256'(header_ecc_ok), 256'(1));
      check("t3_sub2", 256'(sub[2]), 256'(keep_sub2));

      // 4: abort after word 17, then a clean packet
      prior = last_exp;
      a0 = abort_cnt;
      v0 = valid_cnt;
      rand_pkt(b4, b);
      send_pkt(b4, b, 18);
      exp_abort++;
      idle(3);
      check("t4_abort_pulses", 256'(abort_cnt), 256'(a0 + 1));
      check("t4_no_valid", 256'(valid_cnt), 256'(v0));
      check_outputs("t4_hold", prior);
      rand_pkt(b4, b);
      send_pkt(b4, b, 32);
      idle(2);
      check("t4_next_header", 256'(header), 256'(b4[23:0]));

      // 5: three back-to-back packets
      v0 = valid_cnt;
      for (int k = 0; k < 3; k++) begin
         rand_pkt(b4, b);
         send_pkt(b4, b, 32);
      end
      idle(2);
      check("t5_valid_count", 256'(valid_cnt), 256'(v0 + 3));
      sz = valid_cycles.size();
      if (sz >= 3) begin
         check("t5_gap_a", 256'(valid_cycles[sz-2] - valid_cycles[sz-3]), 256'(32));
         check("t5_gap_b", 256'(valid_cycles[sz-1] - valid_cycles[sz-2]), 256'(32));
      end

      // 6: reset pulse at word 10
      a0 = abort_cnt;
      rand_pkt(b4, b);
      send_pkt(b4, b, 10);
      @(negedge clk_pixel);
      reset              = 1'b1;
      data_island_period = 1'b1;
      packet_data        = 9'($urandom);
      @(negedge clk_pixel);
      reset              = 1'b0;
      data_island_period = 1'b0;
      last_exp           = '0;
      check_outputs("t6_reset", '0);
      check("t6_reset_valid", 256'(packet_valid), 256'(0));
      idle(3);
      check("t6_no_abort", 256'(abort_cnt), 256'(a0));
      rand_pkt(b4, b);
      send_pkt(b4, b, 32);
      idle(2);
      check("t6_after_header", 256'(header), 256'(b4[23:0]));
      check("t6_no_abort_after", 256'(abort_cnt), 256'(a0));

      // randomized traffic: corruption, gaps, back-to-back, aborts
      for (int it = 0; it < 30; it++) begin
         r = $urandom_range(0, 7);
         rand_pkt(b4, b);
         if (r == 0) begin
            n = $urandom_range(1, 31);
            send_pkt(b4, b, n);
            exp_abort++;
            idle($urandom_range(2, 3));
            check_outputs("rand_abort_hold", last_exp);
         end else begin
            if (r == 1) begin
               bi = $urandom_range(0, 31);
               b4[bi] = ~b4[bi];
            end else if (r == 2) begin
               si = $urandom_range(0, 3);
               bi = $urandom_range(0, 63);
               b[si][bi] = ~b[si][bi];
            end
            send_pkt(b4, b, 32);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
         end
      end

      idle(2);
      for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk_pixel);
      check("drain", 256'(exp_q.size()), 256'(0));
      check("valid_total", 256'(valid_cnt), 256'(pushed));
      check("abort_total", 256'(abort_cnt), 256'(exp_abort));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
